// File: rtl/mem_if_pkg.sv
// Shared types and constants for the CPU data-memory interface responder.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bit positions of the individual error causes inside an error-cause vector
    localparam int ERR_CONFLICT = 0;
    localparam int ERR_ALIGN    = 1;
    localparam int ERR_RANGE    = 2;
    localparam int ERR_W        = 3;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dm_ram.sv
// Synchronous single-port DEPTH x 32 word array with write enable and a
// registered read port that only updates on enabled reads.
module dm_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Storage is never reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds its value across writes and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: latches one request, waits
// WAIT_CYCLES, then commits/reads the RAM and pulses mem_ready for one cycle.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam int         SH       = $clog2(WORD_BYTES);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    function automatic logic [ERR_W-1:0] err_cause(input logic        rd,
                                                   input logic        wr,
                                                   input logic [31:0] addr);
        logic [31:0] word;
        word                    = (addr - BASE_ADDR) >> SH;
        err_cause               = '0;
        err_cause[ERR_CONFLICT] = rd & wr;
        err_cause[ERR_ALIGN]    = (addr[SH-1:0] != '0);
        err_cause[ERR_RANGE]    = (word >= 32'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        word_idx = AW'((addr - BASE_ADDR) >> SH);
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        wr_q, err_q;

    logic        req, err_now, accept;
    logic        ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    assign req     = mem_read | mem_write;
    assign err_now = |err_cause(mem_read, mem_write, mem_address);
    assign accept  = (state_q == IDLE) && req;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = word_idx(addr_q);
        ram_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access commits on the accept edge itself.
                        state_d   = RESP;
                        ram_en    = !err_now;
                        ram_we    = mem_write;
                        ram_addr  = word_idx(mem_address);
                        ram_wdata = mem_write_data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    ram_en  = !err_q;
                    ram_we  = wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched request copy; later changes on the request lines are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= mem_address;
            wdata_q <= mem_write_data;
            wr_q    <= mem_write;
            err_q   <= err_now;
        end
    end

    dm_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign mem_read_data = ram_rdata;
    assign mem_ready     = (state_q == RESP);
    assign mem_error     = (state_q == RESP) && err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table for single accesses
// plus hand-written reset-abort and zero-wait-state back-to-back sequences.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err, busy;

    logic        b_rd, b_wr;
    logic [31:0] b_addr, b_wdata;
    logic [31:0] b_rdata;
    logic        b_ready, b_err, b_busy;

    int cmp_n  = 0;
    int fail_n = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_read       (rd),
        .mem_write      (wr),
        .mem_address    (addr),
        .mem_write_data (wdata),
        .mem_read_data  (rdata),
        .mem_ready      (ready),
        .mem_error      (err),
        .busy           (busy)
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_read       (b_rd),
        .mem_write      (b_wr),
        .mem_address    (b_addr),
        .mem_write_data (b_wdata),
        .mem_read_data  (b_rdata),
        .mem_ready      (b_ready),
        .mem_error      (b_err),
        .busy           (b_busy)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One access on the WAIT_CYCLES=2 instance; request lines are scrambled after accept.
    task automatic do_access(input string nm, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic e_err, input logic [31:0] e_rdata);
        int edges;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFF3; wdata = 32'h0BAD_F00D;
        check({nm, " busy_wait"}, 32'(busy), 32'd1);
        edges = 0;
        while (!ready && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check({nm, " latency"}, 32'(edges), 32'd2);
        check({nm, " busy_resp"}, 32'(busy), 32'd1);
        check({nm, " error"}, 32'(err), 32'(e_err));
        check({nm, " rdata"}, rdata, e_rdata);
        @(posedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_0BAD, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h9999_9999, 1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 32'h1111_1111};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hAAAA_5555};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'hAAAA_5555};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h7777_7777, 1'b0, 32'hAAAA_5555};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h7777_7777};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};

        rd = 0; wr = 0; addr = 0; wdata = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
        reset_n = 1'b0;
        #3;
        check("rst ready", 32'(ready), 32'd0);
        check("rst error", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst0 ready", 32'(b_ready), 32'd0);
        check("rst0 busy", 32'(b_busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Reset while a write sits in WAIT: no pulse, no commit.
        @(negedge clk);
        wr = 1'b1; addr = 32'h30; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        check("abort busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort ready", 32'(ready), 32'd0);
        check("abort error", 32'(err), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rdata", rdata, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort ready_held", 32'(ready), 32'd0);
        end
        reset_n = 1'b1;
        do_access("abort_readback", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0BAD_0BAD);

        // Zero wait states: write then hold mem_read continuously.
        @(negedge clk);
        b_wr = 1'b1; b_addr = 32'h10; b_wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        @(negedge clk);
        check("w0 write ready", 32'(b_ready), 32'd1);
        check("w0 write error", 32'(b_err), 32'd0);
        check("w0 write rdata", b_rdata, 32'd0);
        b_wr = 1'b0; b_rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("w0 ready c%0d", k), 32'(b_ready), 32'(k % 2));
            check($sformatf("w0 busy c%0d", k), 32'(b_busy), 32'(k % 2));
            if (k % 2 == 1) begin
                check($sformatf("w0 rdata c%0d", k), b_rdata, 32'h5A5A_5A5A);
            end
        end
        b_rd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
